// File: rtl/xaui_pkg.sv
// XAUI link-fault shared types and XGMII ordered-set constants.
// Fault states, column classes and the LF/RF/idle column words.
package xaui_pkg;

  typedef enum logic [1:0] {
    LF_OK     = 2'b00,
    LF_LOCAL  = 2'b01,
    LF_REMOTE = 2'b10
  } link_fault_t;

  localparam logic [7:0] SEQ_CHAR  = 8'h9C;
  localparam logic [7:0] IDLE_CHAR = 8'h07;
  localparam logic [7:0] LF_CODE   = 8'h01;
  localparam logic [7:0] RF_CODE   = 8'h02;

  localparam logic [31:0] LF_WORD =
    {LF_CODE, 8'h00, 8'h00, SEQ_CHAR};
  localparam logic [31:0] RF_WORD =
    {RF_CODE, 8'h00, 8'h00, SEQ_CHAR};
  localparam logic [31:0] IDLE_WORD =
    {4{IDLE_CHAR}};

  // seq_type: 0 = local fault, 1 = remote fault
  typedef struct packed {
    logic is_seq;
    logic seq_type;
  } col_class_t;

  function automatic link_fault_t seq_fault(
    input logic rf
  );
    return rf ? LF_REMOTE : LF_LOCAL;
  endfunction

endpackage

// File: rtl/xgmii_col_classify.sv
// Classifies one 32-bit XGMII column as an LF/RF
// fault sequence or a non-sequence column.
module xgmii_col_classify
  import xaui_pkg::*;
(
  input  logic [31:0] d,
  input  logic [3:0]  c,
  output col_class_t  cls
);

  always_comb begin
    cls.is_seq   = (c == 4'b0001) &&
                   ((d == LF_WORD) || (d == RF_WORD));
    cls.seq_type = (d == RF_WORD);
  end

endmodule

// File: rtl/xaui_link_fault.sv
// XAUI clause-46 link-fault detection, rx LF substitution,
// tx RF/idle override and latched status bits.
module xaui_link_fault
  import xaui_pkg::*;
#(
  parameter  int NUM_COLS   = 2,
  parameter  int SEQ_THRESH = 4,
  parameter  int COL_THRESH = 128,
  localparam int DATA_W     = 32 * NUM_COLS,
  localparam int CTRL_W     = 4 * NUM_COLS
) (
  input  logic              usrclk,
  input  logic              reset_n,
  input  logic              align_status,
  input  logic [DATA_W-1:0] rx_d_in,
  input  logic [CTRL_W-1:0] rx_c_in,
  output logic [DATA_W-1:0] rx_d_out,
  output logic [CTRL_W-1:0] rx_c_out,
  input  logic [DATA_W-1:0] tx_d_in,
  input  logic [CTRL_W-1:0] tx_c_in,
  output logic [DATA_W-1:0] tx_d_out,
  output logic [CTRL_W-1:0] tx_c_out,
  input  logic              cfg_fault_en,
  input  logic              cfg_clr_local_fault,
  input  logic              cfg_clr_link_status,
  output logic [1:0]        link_fault,
  output logic              status_local_fault,
  output logic              status_remote_fault,
  output logic              rx_link_up
);

  localparam int SW = $clog2(SEQ_THRESH + 1);
  localparam int CW = $clog2(COL_THRESH + 1);

  link_fault_t   lf_q, lf_n;
  link_fault_t   last_q, last_n;
  logic [SW-1:0] seq_q, seq_n;
  logic [CW-1:0] col_q, col_n;
  logic          clr_lf_q, clr_ls_q;
  logic          clr_lf_edge, clr_ls_edge;
  col_class_t    cls [NUM_COLS];

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
    xgmii_col_classify u_cls (
      .d   (rx_d_out[32*k +: 32]),
      .c   (rx_c_out[4*k +: 4]),
      .cls (cls[k])
    );
  end

  always_ff @(posedge usrclk) begin
    if (!reset_n) begin
      lf_q   <= LF_OK;
      last_q <= LF_LOCAL;
      seq_q  <= '0;
      col_q  <= '0;
    end else begin
      lf_q   <= lf_n;
      last_q <= last_n;
      seq_q  <= seq_n;
      col_q  <= col_n;
    end
  end

  // Columns chain in order: column k sees column k-1's update
  always_comb begin
    lf_n   = lf_q;
    last_n = last_q;
    seq_n  = seq_q;
    col_n  = col_q;
    for (int k = 0; k < NUM_COLS; k++) begin
      if (cls[k].is_seq) begin
        if (seq_fault(cls[k].seq_type) == last_n) begin
          if (seq_n < SW'(SEQ_THRESH))
            seq_n = seq_n + SW'(1);
        end else begin
          seq_n  = SW'(1);
          last_n = seq_fault(cls[k].seq_type);
        end
        col_n = '0;
        if (seq_n == SW'(SEQ_THRESH))
          lf_n = last_n;
      end else begin
        if (col_n < CW'(COL_THRESH))
          col_n = col_n + CW'(1);
        if (col_n == CW'(COL_THRESH)) begin
          seq_n = '0;
          col_n = '0;
          lf_n  = LF_OK;
        end
      end
    end
  end

  always_comb link_fault = lf_q;

  always_ff @(posedge usrclk) begin
    if (!reset_n || !align_status) begin
      rx_d_out <= {NUM_COLS{LF_WORD}};
      rx_c_out <= {NUM_COLS{4'b0001}};
    end else begin
      rx_d_out <= rx_d_in;
      rx_c_out <= rx_c_in;
    end
  end

  always_ff @(posedge usrclk) begin
    if (!reset_n) begin
      tx_d_out <= {NUM_COLS{IDLE_WORD}};
      tx_c_out <= '1;
    end else if (!cfg_fault_en || lf_q == LF_OK) begin
      tx_d_out <= tx_d_in;
      tx_c_out <= tx_c_in;
    end else if (lf_q == LF_LOCAL) begin
      tx_d_out <= {NUM_COLS{RF_WORD}};
      tx_c_out <= {NUM_COLS{4'b0001}};
    end else begin
      tx_d_out <= {NUM_COLS{IDLE_WORD}};
      tx_c_out <= '1;
    end
  end

  assign clr_lf_edge = cfg_clr_local_fault & ~clr_lf_q;
  assign clr_ls_edge = cfg_clr_link_status & ~clr_ls_q;

  // Set conditions take priority over the clear edges
  always_ff @(posedge usrclk) begin
    if (!reset_n) begin
      clr_lf_q            <= 1'b0;
      clr_ls_q            <= 1'b0;
      status_local_fault  <= 1'b1;
      status_remote_fault <= 1'b0;
      rx_link_up          <= 1'b0;
    end else begin
      clr_lf_q <= cfg_clr_local_fault;
      clr_ls_q <= cfg_clr_link_status;
      if (lf_q == LF_LOCAL || !align_status)
        status_local_fault <= 1'b1;
      else if (clr_lf_edge)
        status_local_fault <= 1'b0;
      if (lf_q == LF_REMOTE)
        status_remote_fault <= 1'b1;
      else if (clr_lf_edge)
        status_remote_fault <= 1'b0;
      if (!align_status || lf_q != LF_OK)
        rx_link_up <= 1'b0;
      else if (clr_ls_edge)
        rx_link_up <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xaui_link_fault.sv
// Directed self-checking bench for xaui_link_fault,
// two-column and single-column builds.
module tb_xaui_link_fault;
  import xaui_pkg::*;

  localparam logic [63:0] IDLE2 = 64'h0707070707070707;
  localparam logic [63:0] LF2   = 64'h0100009C0100009C;
  localparam logic [63:0] RF2   = 64'h0200009C0200009C;
  localparam logic [63:0] TXD   = 64'h1122334455667788;

  logic usrclk = 1'b0;
  always #5 usrclk = ~usrclk;

  int errors = 0;
  int checks = 0;

  logic        reset_n, rst1_n, align;
  logic        en, clr_lf, clr_ls;
  logic [63:0] rx_d, rx_d_o, tx_d, tx_d_o;
  logic [7:0]  rx_c, rx_c_o, tx_c, tx_c_o;
  logic [1:0]  lf;
  logic        st_l, st_r, up;
  logic [31:0] rx_d1, rx_d1_o, tx_d1, tx_d1_o;
  logic [3:0]  rx_c1, rx_c1_o, tx_c1, tx_c1_o;
  logic [1:0]  lf1;
  logic        st_l1, st_r1, up1;

  xaui_link_fault #(.NUM_COLS(2)) u2 (
    .usrclk              (usrclk),
    .reset_n             (reset_n),
    .align_status        (align),
    .rx_d_in             (rx_d),
    .rx_c_in             (rx_c),
    .rx_d_out            (rx_d_o),
    .rx_c_out            (rx_c_o),
    .tx_d_in             (tx_d),
    .tx_c_in             (tx_c),
    .tx_d_out            (tx_d_o),
    .tx_c_out            (tx_c_o),
    .cfg_fault_en        (en),
    .cfg_clr_local_fault (clr_lf),
    .cfg_clr_link_status (clr_ls),
    .link_fault          (lf),
    .status_local_fault  (st_l),
    .status_remote_fault (st_r),
    .rx_link_up          (up)
  );

  xaui_link_fault #(.NUM_COLS(1)) u1 (
    .usrclk              (usrclk),
    .reset_n             (rst1_n),
    .align_status        (align),
    .rx_d_in             (rx_d1),
    .rx_c_in             (rx_c1),
    .rx_d_out            (rx_d1_o),
    .rx_c_out            (rx_c1_o),
    .tx_d_in             (tx_d1),
    .tx_c_in             (tx_c1),
    .tx_d_out            (tx_d1_o),
    .tx_c_out            (tx_c1_o),
    .cfg_fault_en        (en),
    .cfg_clr_local_fault (clr_lf),
    .cfg_clr_link_status (clr_ls),
    .link_fault          (lf1),
    .status_local_fault  (st_l1),
    .status_remote_fault (st_r1),
    .rx_link_up          (up1)
  );

  task automatic tick;
    @(posedge usrclk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 0; rst1_n = 0; align = 1;
    en = 1; clr_lf = 0; clr_ls = 0;
    rx_d = IDLE2; rx_c = 8'hFF;
    tx_d = TXD; tx_c = 8'h00;
    rx_d1 = 32'h07070707; rx_c1 = 4'hF;
    tx_d1 = 32'hCAFEF00D; tx_c1 = 4'h0;
    tick; tick;
    chk("rst_lf", 64'(lf), 64'd0);
    chk("rst_st_l", 64'(st_l), 64'd1);
    chk("rst_st_r", 64'(st_r), 64'd0);
    chk("rst_up", 64'(up), 64'd0);
    chk("rst_rxd", rx_d_o, LF2);
    chk("rst_rxc", 64'(rx_c_o), 64'h11);
    chk("rst_txd", tx_d_o, IDLE2);
    chk("rst_txc", 64'(tx_c_o), 64'hFF);
    reset_n = 1; rst1_n = 1;
    repeat (70) tick;
    chk("idle_lf", 64'(lf), 64'd0);
    chk("idle_up_latched", 64'(up), 64'd0);
    chk("idle_txd_pass", tx_d_o, TXD);
    clr_lf = 1; tick; clr_lf = 0;
    chk("clr_st_l", 64'(st_l), 64'd0);
    chk("clr_st_r", 64'(st_r), 64'd0);
    clr_ls = 1; tick; clr_ls = 0;
    chk("clr_up", 64'(up), 64'd1);

    // Four RF columns over two words
    rx_d = RF2; rx_c = 8'h11;
    tick; tick;
    chk("rf_rxd", rx_d_o, RF2);
    chk("rf_lf_half", 64'(lf), 64'd0);
    rx_d = IDLE2; rx_c = 8'hFF;
    tick;
    chk("rf_lf", 64'(lf), 64'd2);
    chk("rf_tx_prev", tx_d_o, TXD);
    tick;
    chk("rf_txd", tx_d_o, IDLE2);
    chk("rf_txc", 64'(tx_c_o), 64'hFF);
    chk("rf_st_r", 64'(st_r), 64'd1);
    chk("rf_up", 64'(up), 64'd0);
    en = 0; tick;
    chk("rf_tx_dis", tx_d_o, TXD);
    en = 1;
    repeat (70) tick;
    chk("rf_back_ok", 64'(lf), 64'd0);

    // LF,LF | LF,RF | LF,LF | LF,idle | LF,LF
    rx_d = LF2; rx_c = 8'h11; tick;
    rx_d = 64'h0200009C0100009C; tick;
    rx_d = LF2; tick;
    rx_d = 64'h070707070100009C; rx_c = 8'hF1; tick;
    rx_d = LF2; rx_c = 8'h11; tick;
    chk("mix_ok", 64'(lf), 64'd0);
    rx_d = IDLE2; rx_c = 8'hFF; tick;
    chk("mix_local", 64'(lf), 64'd1);
    tick;
    chk("loc_txd", tx_d_o, RF2);
    chk("loc_txc", 64'(tx_c_o), 64'h11);
    chk("loc_st_l", 64'(st_l), 64'd1);

    // 127 idle columns then LF at column 127
    repeat (61) tick;
    rx_d = 64'h0100009C07070707; rx_c = 8'h1F; tick;
    rx_d = IDLE2; rx_c = 8'hFF; tick;
    chk("col127_restart", 64'(lf), 64'd1);
    repeat (63) tick;
    chk("col126_local", 64'(lf), 64'd1);
    tick;
    chk("col128_ok", 64'(lf), 64'd0);

    clr_lf = 1; tick; clr_lf = 0;
    chk("clr2_st_l", 64'(st_l), 64'd0);
    chk("clr2_st_r", 64'(st_r), 64'd0);
    clr_ls = 1; tick; clr_ls = 0;
    chk("clr2_up", 64'(up), 64'd1);
    align = 0; clr_lf = 1; tick; align = 1;
    chk("nal_rxd", rx_d_o, LF2);
    chk("nal_rxc", 64'(rx_c_o), 64'h11);
    chk("nal_st_l", 64'(st_l), 64'd1);
    chk("nal_up", 64'(up), 64'd0);
    clr_lf = 0; tick;
    chk("nal_up_held", 64'(up), 64'd0);
    chk("nal_st_l_held", 64'(st_l), 64'd1);

    // Single-column build
    rx_d1 = RF_WORD; rx_c1 = 4'h1;
    repeat (4) tick;
    chk("c1_ok", 64'(lf1), 64'd0);
    rx_d1 = 32'h07070707; rx_c1 = 4'hF; tick;
    chk("c1_remote", 64'(lf1), 64'd2);
    tick;
    chk("c1_txd", 64'(tx_d1_o), 64'h07070707);
    rx_d1 = RF_WORD; rx_c1 = 4'h1;
    tick; tick;
    rst1_n = 0; tick;
    chk("c1_rst_lf", 64'(lf1), 64'd0);
    chk("c1_rst_st_l", 64'(st_l1), 64'd1);
    chk("c1_rst_st_r", 64'(st_r1), 64'd0);
    chk("c1_rst_up", 64'(up1), 64'd0);
    chk("c1_rst_rxd", 64'(rx_d1_o), 64'(LF_WORD));
    chk("c1_rst_rxc", 64'(rx_c1_o), 64'h1);
    chk("c1_rst_txd", 64'(tx_d1_o), 64'h07070707);
    chk("c1_rst_txc", 64'(tx_c1_o), 64'hF);
    rst1_n = 1;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/xaui_link_fault.md
Name: xaui_link_fault

Overview:
- Parametrised successor to the XAUI PCS status/fault logic.
- Sits between the PCS (pcs_rx/pcs_tx) and the MAC on the XGMII side, with NUM_COLS 32-bit XGMII columns per usrclk word.
- Implements IEEE 802.3 clause 46 link-fault signalling:
  - On the rx path, substitutes local-fault ordered sets while deskew is lost.
  - Detects local/remote fault sequences with sequence and column counters.
  - On the tx path, overrides outgoing data with remote-fault or idle.
- Maintains latched, software-clearable status bits.

Parameters:
- NUM_COLS, 2, XGMII columns per word (1 or 2); DATA_W=32*NUM_COLS, CTRL_W=4*NUM_COLS.
- SEQ_THRESH, 4, consecutive same-type fault sequences needed to enter a fault state.
- COL_THRESH, 128, non-sequence columns after which the link returns to OK.

Ports:
- usrclk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- align_status  in  1  deskew aligned, from pcs_deskew
- rx_d_in  in  DATA_W  XGMII rx data from pcs_rx; column k = bits [32k+31:32k], lane0 in the low byte
- rx_c_in  in  CTRL_W  rx control, bit 4k+j = lane j of column k
- rx_d_out  out  DATA_W  rx data to MAC
- rx_c_out  out  CTRL_W  rx control to MAC
- tx_d_in  in  DATA_W  tx data from MAC
- tx_c_in  in  CTRL_W  tx control from MAC
- tx_d_out  out  DATA_W  tx data to pcs_tx
- tx_c_out  out  CTRL_W  tx control to pcs_tx
- cfg_fault_en  in  1  1 = tx override enabled
- cfg_clr_local_fault  in  1  rising edge clears latched fault bits
- cfg_clr_link_status  in  1  rising edge re-samples rx_link_up
- link_fault  out  2  00 OK, 01 LOCAL, 10 REMOTE
- status_local_fault  out  1  latched-high local fault
- status_remote_fault  out  1  latched-high remote fault
- rx_link_up  out  1  latched-low link status

Behaviour:

Reset (reset_n=0 at a usrclk edge) drives these values:
- link_fault=OK; seq_cnt=0; col_cnt=0; last_type=LOCAL.
- status_local_fault=1; status_remote_fault=0; rx_link_up=0.
- rx_d_out = LF set in every column, rx_c_out = 0x1 per column.
- tx_d_out = 0x07 in all bytes, tx_c_out all ones.
- Previous-value registers of both cfg_clr inputs = 0.

Column definitions:
- LF set: ctrl 0001, lanes = 9C,00,00,01 (word 0x0100009C).
- RF set: ctrl 0001, word 0x0200009C.
- Any other column is a non-sequence column.

Rx path, 1-cycle latency:
- If align_status=0, every output column is the LF set.
- Otherwise rx_d_in/rx_c_in pass through.
- The fault state machine evaluates the registered rx_d_out/rx_c_out.

Fault state machine:
- Columns are evaluated in order 0..NUM_COLS-1 within one cycle, chained combinationally; column k sees the updates from column k-1.
- Fault column of type t:
  - If t==last_type, seq_cnt++ (saturate at SEQ_THRESH); else seq_cnt=1 and last_type=t.
  - col_cnt=0.
  - When seq_cnt reaches SEQ_THRESH, link_fault=t.
- Non-sequence column:
  - col_cnt++ (saturate).
  - When col_cnt reaches COL_THRESH: seq_cnt=0, col_cnt=0, link_fault=OK.
- link_fault updates 1 cycle after rx_d_out carries the deciding column.

Tx path, 1-cycle latency, using the link_fault value registered in the current cycle:
- cfg_fault_en=0 or OK: pass-through.
- LOCAL: every column = RF set.
- REMOTE: every column = idle (0x07 bytes, ctrl 1111).

Status:
- status_local_fault sets when link_fault=LOCAL or align_status=0.
- status_remote_fault sets when link_fault=REMOTE.
- Both clear on a rising edge of cfg_clr_local_fault; a set condition in the same cycle wins.
- rx_link_up:
  - On a rising edge of cfg_clr_link_status, loads (align_status & link_fault==OK).
  - Forced 0 whenever align_status=0 or link_fault≠OK; the force wins over the load.
- Reset asserted mid-sequence discards all counts.

Decomposition:
- Package xaui_pkg:
  - link_fault_t enum (OK/LOCAL/REMOTE).
  - Constants SEQ_CHAR 0x9C, IDLE_CHAR 0x07, LF_CODE 0x01, RF_CODE 0x02, LF_WORD, RF_WORD.
- Sub-module xgmii_col_classify, one instance per column: 32-bit data + 4-bit ctrl in, {is_seq, seq_type} out.

Test Plan:
- align_status=1, NUM_COLS=2, four consecutive RF columns (2 words) → link_fault=REMOTE the cycle after the second word reaches rx_d_out; with cfg_fault_en=1, tx_d_out = 0x0707070707070707 and tx_c_out=0xFF.
- 3 LF, 1 RF, 3 LF columns → seq_cnt restarts on the type change; link_fault stays OK; the 4th consecutive LF column sets LOCAL; tx_d_out = 0x0200009C_0200009C, tx_c_out=0x11.
- In LOCAL, send 128 idle columns (64 words) → link_fault returns to OK exactly after the 128th column; a fault column at column 127 restarts col_cnt.
- Drop align_status for 1 cycle → rx_d_out = LF sets the next cycle, status_local_fault=1, rx_link_up=0.
- Clear-edge checks:
  - Rising edge of cfg_clr_local_fault while aligned and OK → status bits clear.
  - The same edge while align_status=0 → bits stay 1.
  - Rising edge of cfg_clr_link_status while OK → rx_link_up=1.
- NUM_COLS=1 build: four RF columns in 4 consecutive cycles → REMOTE; reset_n=0 mid-sequence → all reset values restored next cycle.
